// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// No ports. Exposes XLEN/ILEN, the NOP encoding, the FSM state type and
// the queue entry layout.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    FQ_RUN   = 1'b0,
    FQ_FLUSH = 1'b1
  } fq_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory, branch
// resolution and the ID stage.
//   master : fetch queue side (drives imem request and id_* outputs)
//   slave  : environment side (memory, redirect source, ID stage)
interface fetch_queue_if;

  logic                               imem_req_valid;
  logic                               imem_req_ready;
  logic [fetch_queue_pkg::XLEN-1:0]   imem_req_addr;
  logic                               imem_rsp_valid;
  logic [fetch_queue_pkg::ILEN-1:0]   imem_rsp_data;
  logic                               redirect_valid;
  logic [fetch_queue_pkg::XLEN-1:0]   redirect_pc;
  logic                               id_valid;
  logic                               id_ready;
  logic [fetch_queue_pkg::XLEN-1:0]   id_pc;
  logic [fetch_queue_pkg::ILEN-1:0]   id_instr;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_queue_ptr.sv
// Queue pointer with wrap bit.
//   clk, rst : clock, synchronous active-low reset
//   i_clr    : return pointer to zero (wins over i_inc)
//   i_inc    : advance by one, wrapping through the extra MSB
//   o_ptr    : current pointer value
module fetch_queue_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: DEPTH-entry prefetch queue between iMem and ID.
//   clk, rst : clock, synchronous active-low reset
//   bus      : fetch_queue_if.master (imem request/response, redirect, ID handshake)
// Optional feature: define FETCHQ_BYPASS_EN to forward a response straight to
// ID when it lands on an empty head entry (one cycle less fetch-to-decode).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  fq_entry_t       r_entry [DEPTH];
  logic [XLEN-1:0] r_pc;
  fq_state_t       r_state;
  fq_state_t       w_state_nxt;
  logic [PW-1:0]   r_stale_cnt;
  logic [PW-1:0]   w_stale_nxt;

  logic [PW-1:0]   w_head, w_fill, w_tail;
  logic [PW-1:0]   w_used;
  logic [PW-1:0]   w_outstanding;
  logic [AW-1:0]   w_head_idx, w_fill_idx, w_tail_idx;
  fq_entry_t       w_head_ent;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_req_valid, w_issue, w_rsp_run, w_byp, w_id_valid, w_deq;
  logic            w_fill_write;

  assign w_used     = w_tail - w_head;
  assign w_head_idx = w_head[AW-1:0];
  assign w_fill_idx = w_fill[AW-1:0];
  assign w_tail_idx = w_tail[AW-1:0];
  assign w_head_ent = r_entry[w_head_idx];
  assign w_redir_pc = bus.redirect_pc & ~XLEN'(3);

  // Issue is held off during reset so nothing is requested before state is valid.
  assign w_req_valid = rst && (r_state == FQ_RUN) && (w_used < PW'(DEPTH))
                       && !bus.redirect_valid;
  assign w_issue     = w_req_valid && bus.imem_req_ready;
  assign w_rsp_run   = (r_state == FQ_RUN) && bus.imem_rsp_valid;

`ifdef FETCHQ_BYPASS_EN
  // Response belongs to the head entry: present it to ID in the same cycle.
  assign w_byp = w_rsp_run && !w_head_ent.filled && (w_head == w_fill);
`else
  assign w_byp = 1'b0;
`endif

  assign w_id_valid   = w_head_ent.filled || w_byp;
  assign w_deq        = w_id_valid && bus.id_ready;
  // A bypassed response consumed by ID never needs to be stored.
  assign w_fill_write = w_rsp_run && !(w_byp && bus.id_ready);

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.id_valid       = w_id_valid;
  assign bus.id_pc          = w_head_ent.pc;
  assign bus.id_instr       = !w_id_valid ? NOP_INSTR
                            : (w_byp ? bus.imem_rsp_data : w_head_ent.instr);

  // Pointers; redirect clears all three regardless of same-cycle activity.
  fetch_queue_ptr #(.W(PW)) u_head (
    .clk(clk), .rst(rst), .i_clr(bus.redirect_valid), .i_inc(w_deq), .o_ptr(w_head)
  );
  fetch_queue_ptr #(.W(PW)) u_fill (
    .clk(clk), .rst(rst), .i_clr(bus.redirect_valid), .i_inc(w_rsp_run), .o_ptr(w_fill)
  );
  fetch_queue_ptr #(.W(PW)) u_tail (
    .clk(clk), .rst(rst), .i_clr(bus.redirect_valid), .i_inc(w_issue), .o_ptr(w_tail)
  );

  // In FLUSH the queue is empty, so the stale counter is the only in-flight record.
  assign w_outstanding = (r_state == FQ_FLUSH) ? r_stale_cnt : (w_tail - w_fill);

  // FSM next state and stale-response accounting.
  always_comb begin
    w_state_nxt = r_state;
    w_stale_nxt = r_stale_cnt;
    if (bus.redirect_valid) begin
      w_stale_nxt = w_outstanding - PW'(bus.imem_rsp_valid);
      w_state_nxt = (w_stale_nxt == '0) ? FQ_RUN : FQ_FLUSH;
    end else begin
      case (r_state)
        FQ_FLUSH: begin
          if (bus.imem_rsp_valid) begin
            w_stale_nxt = r_stale_cnt - PW'(1);
            if (r_stale_cnt == PW'(1)) begin
              w_state_nxt = FQ_RUN;
            end
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= FQ_RUN;
      r_stale_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stale_cnt <= w_stale_nxt;
    end
  end

  // Fetch PC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_pc <= w_redir_pc;
    end else if (w_issue) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  // Entry storage; filled is cleared on dequeue so an empty head never reads valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_entry[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
      end
    end else if (bus.redirect_valid) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_entry[i].filled <= 1'b0;
      end
    end else begin
      if (w_issue) begin
        r_entry[w_tail_idx].pc     <= r_pc;
        r_entry[w_tail_idx].filled <= 1'b0;
      end
      if (w_fill_write) begin
        r_entry[w_fill_idx].instr  <= bus.imem_rsp_data;
        r_entry[w_fill_idx].filled <= 1'b1;
      end
      if (w_deq) begin
        r_entry[w_head_idx].filled <= 1'b0;
      end
    end
  end

  // Responses can only return for requests that are still outstanding.
  a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst)
    !(w_rsp_run && (w_fill == w_tail)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomised
// run against an in-order, variable-latency memory model and a PC scoreboard.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef FETCHQ_BYPASS_EN
  localparam int FIRST_VALID = 2;
`else
  localparam int FIRST_VALID = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Memory model controls and state
  int  mem_lat      = 1;
  bit  mem_lat_rand = 1'b0;
  bit  mem_rdy_rand = 1'b0;
  int  mem_cyc      = 0;
  logic [XLEN-1:0] pend_addr[$];
  int              pend_due[$];

  function automatic logic [ILEN-1:0] mem_data(input logic [XLEN-1:0] a);
    return a[ILEN-1:0] ^ 32'hC0DE_0000;
  endfunction

  // In-order memory: response for an accept in cycle c is presented in cycle c+1+lat.
  initial begin : mem_model
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_cyc++;
      bus.imem_req_ready = mem_rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
      if (pend_addr.size() > 0 && pend_due[0] <= mem_cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_data(pend_addr[0]);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
      @(negedge clk);
      if (!rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else begin
        if (bus.imem_rsp_valid) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          pend_addr.push_back(bus.imem_req_addr);
          pend_due.push_back(mem_cyc + 1 + (mem_lat_rand ? int'($urandom_range(5)) : mem_lat));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    next();
    next();
  endtask

  task automatic test_reset();
    mem_lat = 1; mem_lat_rand = 1'b0; mem_rdy_rand = 1'b0;
    do_reset();
    smp();
    n_run++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
    n_run++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    n_run++; if (bus.id_pc !== 64'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); end
    n_run++; if (bus.id_instr !== 32'h00000013) begin n_fail++; $display("FAIL reset_id_instr: got %h want 00000013", bus.id_instr); end
    n_run++; if (dut.r_state !== FQ_RUN) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dut.r_state); end
    n_run++; if (dut.r_stale_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_stale: got %0d want 0", dut.r_stale_cnt); end
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] exp_pc;
    int first;
    mem_lat = 1; mem_lat_rand = 1'b0; mem_rdy_rand = 1'b0;
    do_reset();
    rst = 1'b1;
    bus.id_ready = 1'b1;
    exp_pc = '0;
    first  = -1;
    for (int c = 0; c < 16; c++) begin
      smp();
      n_run++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== XLEN'(4 * c)) begin
        n_fail++;
        $display("FAIL stream_req c=%0d: got v=%b a=%h want v=1 a=%h", c, bus.imem_req_valid, bus.imem_req_addr, XLEN'(4 * c));
      end
      if (bus.id_valid === 1'b1) begin
        if (first < 0) first = c;
        n_run++;
        if (bus.id_pc !== exp_pc || bus.id_instr !== mem_data(exp_pc)) begin
          n_fail++;
          $display("FAIL stream_id c=%0d: got pc=%h i=%h want pc=%h i=%h", c, bus.id_pc, bus.id_instr, exp_pc, mem_data(exp_pc));
        end
        exp_pc = exp_pc + 64'd4;
      end
      next();
    end
    n_run++; if (first != FIRST_VALID) begin n_fail++; $display("FAIL stream_first_valid: got %0d want %0d", first, FIRST_VALID); end
    n_run++;
    if (exp_pc !== XLEN'(4 * (16 - FIRST_VALID))) begin
      n_fail++; $display("FAIL stream_count: got %h want %h", exp_pc, XLEN'(4 * (16 - FIRST_VALID)));
    end
  endtask

  task automatic test_stall();
    logic [XLEN-1:0] exp_pc;
    logic [XLEN-1:0] first_addr;
    int n_iss, n_deq;
    bit got;
    mem_lat = 1; mem_lat_rand = 1'b0; mem_rdy_rand = 1'b0;
    do_reset();
    rst = 1'b1;
    bus.id_ready = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (bus.imem_req_valid && bus.imem_req_ready) n_iss++;
      if (c == 9) begin
        n_run++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_low: got %b want 0", bus.imem_req_valid); end
      end
      next();
    end
    n_run++; if (n_iss != 4) begin n_fail++; $display("FAIL stall_issued: got %0d want 4", n_iss); end
    bus.id_ready = 1'b1;
    exp_pc = '0; first_addr = '1; got = 1'b0; n_deq = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (bus.id_valid === 1'b1) begin
        n_run++;
        if (bus.id_pc !== exp_pc || bus.id_instr !== mem_data(exp_pc)) begin
          n_fail++;
          $display("FAIL stall_id: got pc=%h i=%h want pc=%h i=%h", bus.id_pc, bus.id_instr, exp_pc, mem_data(exp_pc));
        end
        exp_pc = exp_pc + 64'd4;
        n_deq++;
      end
      if (!got && bus.imem_req_valid && bus.imem_req_ready) begin
        got = 1'b1;
        first_addr = bus.imem_req_addr;
      end
      next();
    end
    n_run++; if (n_deq < 4) begin n_fail++; $display("FAIL stall_drain: got %0d want >=4", n_deq); end
    n_run++; if (!got || first_addr !== 64'h10) begin n_fail++; $display("FAIL stall_resume: got seen=%b a=%h want a=10", got, first_addr); end
  endtask

  task automatic test_redirect_flush();
    bit seen, id_bad;
    int k, seen_cyc, n_drop;
    logic [XLEN-1:0] seen_addr;
    mem_lat = 5; mem_lat_rand = 1'b0; mem_rdy_rand = 1'b0;
    do_reset();
    rst = 1'b1;
    bus.id_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin smp(); next(); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    smp();
    n_run++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_in_redirect: got %b want 0", bus.imem_req_valid); end
    next();
    bus.redirect_valid = 1'b0;
    smp();
    n_run++; if (dut.r_state !== FQ_FLUSH) begin n_fail++; $display("FAIL flush_state: got %0d want 1", dut.r_state); end
    n_run++; if (dut.r_stale_cnt !== 3'd3) begin n_fail++; $display("FAIL flush_stale: got %0d want 3", dut.r_stale_cnt); end
    seen = 1'b0; id_bad = 1'b0; n_drop = 0; seen_cyc = -1; seen_addr = '0; k = 0;
    while (!seen && k < 20) begin
      if (k > 0) smp();
      if (bus.id_valid === 1'b1) id_bad = 1'b1;
      if (bus.imem_req_valid === 1'b1) begin
        seen = 1'b1; seen_cyc = 4 + k; seen_addr = bus.imem_req_addr;
      end else if (bus.imem_rsp_valid) begin
        n_drop++;
      end
      next();
      k++;
    end
    n_run++; if (!seen) begin n_fail++; $display("FAIL flush_timeout: got no request want request by cycle 9"); end
    n_run++; if (seen_addr !== 64'h100) begin n_fail++; $display("FAIL flush_addr: got %h want 100", seen_addr); end
    n_run++; if (seen_cyc != 9) begin n_fail++; $display("FAIL flush_resume_cycle: got %0d want 9", seen_cyc); end
    n_run++; if (n_drop != 3) begin n_fail++; $display("FAIL flush_dropped: got %0d want 3", n_drop); end
    n_run++; if (id_bad) begin n_fail++; $display("FAIL flush_id_valid: got 1 want 0"); end
  endtask

  task automatic test_redirect_collide();
    mem_lat = 1; mem_lat_rand = 1'b0; mem_rdy_rand = 1'b0;
    do_reset();
    rst = 1'b1;
    bus.id_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin smp(); next(); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h200;
    smp();
    n_run++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL collide_req: got %b want 0", bus.imem_req_valid); end
    n_run++; if ((dut.w_tail - dut.w_fill) !== 3'd2) begin n_fail++; $display("FAIL collide_outstanding: got %0d want 2", dut.w_tail - dut.w_fill); end
    next();
    bus.redirect_valid = 1'b0;
    smp();
    n_run++; if (dut.r_state !== FQ_FLUSH) begin n_fail++; $display("FAIL collide_state: got %0d want 1", dut.r_state); end
    n_run++; if (dut.r_stale_cnt !== 3'd1) begin n_fail++; $display("FAIL collide_stale: got %0d want 1", dut.r_stale_cnt); end
    n_run++; if ((dut.w_tail - dut.w_head) !== 3'd0 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL collide_empty: got used=%0d v=%b want used=0 v=0", dut.w_tail - dut.w_head, bus.id_valid);
    end
    next();
    smp();
    n_run++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h200) begin
      n_fail++; $display("FAIL collide_resume: got v=%b a=%h want v=1 a=200", bus.imem_req_valid, bus.imem_req_addr);
    end
    next();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] exp_pc;
    int n_deq;
    mem_lat_rand = 1'b1; mem_rdy_rand = 1'b1;
    do_reset();
    rst = 1'b1;
    exp_pc = '0;
    n_deq  = 0;
    for (int c = 0; c < 10000; c++) begin
      bus.id_ready = ($urandom_range(3) != 0);
      if ($urandom_range(39) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = XLEN'($urandom_range(4095));
      end else begin
        bus.redirect_valid = 1'b0;
      end
      smp();
      if (bus.id_valid === 1'b1 && bus.id_ready) begin
        n_run++;
        if (bus.id_pc !== exp_pc || bus.id_instr !== mem_data(exp_pc)) begin
          n_fail++;
          $display("FAIL random_id c=%0d: got pc=%h i=%h want pc=%h i=%h", c, bus.id_pc, bus.id_instr, exp_pc, mem_data(exp_pc));
        end
        exp_pc = exp_pc + 64'd4;
        n_deq++;
      end
      if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~64'h3;
      n_run++;
      if (pend_addr.size() > int'(DEPTH)) begin
        n_fail++; $display("FAIL random_inflight c=%0d: got %0d want <=%0d", c, pend_addr.size(), DEPTH);
      end
      next();
    end
    bus.redirect_valid = 1'b0;
    n_run++; if (n_deq < 500) begin n_fail++; $display("FAIL random_progress: got %0d want >=500", n_deq); end
  endtask

  task automatic test_reset_midflush();
    bit seen;
    int k;
    mem_lat = 5; mem_lat_rand = 1'b0; mem_rdy_rand = 1'b0;
    do_reset();
    rst = 1'b1;
    bus.id_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin smp(); next(); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h300;
    smp();
    next();
    bus.redirect_valid = 1'b0;
    smp();
    n_run++; if (dut.r_state !== FQ_FLUSH) begin n_fail++; $display("FAIL midrst_pre_state: got %0d want 1", dut.r_state); end
    next();
    rst = 1'b0;
    smp();
    next();
    smp();
    n_run++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_id_valid: got %b want 0", bus.id_valid); end
    n_run++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b want 0", bus.imem_req_valid); end
    n_run++; if (bus.id_pc !== 64'h0) begin n_fail++; $display("FAIL midrst_id_pc: got %h want 0", bus.id_pc); end
    n_run++; if (bus.id_instr !== 32'h00000013) begin n_fail++; $display("FAIL midrst_id_instr: got %h want 00000013", bus.id_instr); end
    n_run++; if (dut.r_state !== FQ_RUN) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", dut.r_state); end
    n_run++; if (dut.r_stale_cnt !== 3'd0) begin n_fail++; $display("FAIL midrst_stale: got %0d want 0", dut.r_stale_cnt); end
    next();
    rst = 1'b1;
    smp();
    n_run++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h0) begin
      n_fail++; $display("FAIL midrst_restart: got v=%b a=%h want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr);
    end
    next();
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      smp();
      if (bus.id_valid === 1'b1) begin
        seen = 1'b1;
        n_run++;
        if (bus.id_pc !== 64'h0 || bus.id_instr !== mem_data(64'h0)) begin
          n_fail++; $display("FAIL midrst_first_id: got pc=%h i=%h want pc=0 i=%h", bus.id_pc, bus.id_instr, mem_data(64'h0));
        end
      end
      next();
      k++;
    end
    n_run++; if (!seen) begin n_fail++; $display("FAIL midrst_timeout: got no id_valid want one within 20 cycles"); end
  endtask

  initial begin : main
    rst = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_collide();
    test_random();
    test_reset_midflush();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
